// File: rtl/apx_float_op_driver.sv
// Initiator for the apx float operator stb/ack protocol: sends A, then B,
// collects Z and returns it on a valid/ready port, with a per-phase watchdog.
module apx_float_op_driver #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_z,
  output logic             rsp_err,
  output logic [31:0]      op_a,
  output logic             op_a_stb,
  input  logic             op_a_ack,
  output logic [31:0]      op_b,
  output logic             op_b_stb,
  input  logic             op_b_ack,
  input  logic [31:0]      op_z,
  input  logic             op_z_stb,
  output logic             op_z_ack,
  output logic             busy,
  output logic             stall_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [31:0] ABORT_Z = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    HOLD_RSP
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            xfer;
  logic            expire;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign expire    = (wd == WD_W'(TIMEOUT - 1));

  // Handshake completion of whichever phase is active.
  always_comb begin
    xfer = 1'b0;
    unique case (state)
      SEND_A:  xfer = op_a_stb & op_a_ack;
      SEND_B:  xfer = op_b_stb & op_b_ack;
      WAIT_Z:  xfer = op_z_stb & op_z_ack;
      default: xfer = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wd        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_a_stb  <= 1'b0;
      op_b_stb  <= 1'b0;
      op_z_ack  <= 1'b0;
      rsp_z     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      stall_err <= 1'b0;
      done_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (cmd_valid) begin
            op_a     <= cmd_a;
            op_b     <= cmd_b;
            op_a_stb <= 1'b1;
            state    <= SEND_A;
          end
        end
        HOLD_RSP: begin
          wd <= '0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          // A transfer on the expiry edge still completes normally.
          if (xfer) begin
            wd <= '0;
            unique case (state)
              SEND_A: begin
                op_a_stb <= 1'b0;
                op_b_stb <= 1'b1;
                state    <= SEND_B;
              end
              SEND_B: begin
                op_b_stb <= 1'b0;
                op_z_ack <= 1'b1;
                state    <= WAIT_Z;
              end
              default: begin
                rsp_z     <= op_z;
                op_z_ack  <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                done_cnt  <= done_cnt + 1'b1;
                state     <= HOLD_RSP;
              end
            endcase
          end else if (expire) begin
            wd        <= '0;
            op_a_stb  <= 1'b0;
            op_b_stb  <= 1'b0;
            op_z_ack  <= 1'b0;
            rsp_z     <= ABORT_Z;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            stall_err <= 1'b1;
            state     <= HOLD_RSP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apx_float_op_driver.sv
// Bench for apx_float_op_driver: a delay-programmable operator model
// and a transaction-level expectation of result, error and counters.
module tb_apx_float_op_driver;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_a = '0;
  logic [31:0]   cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_z;
  logic          rsp_err;
  logic [31:0]   op_a;
  logic          op_a_stb;
  logic          op_a_ack = 1'b0;
  logic [31:0]   op_b;
  logic          op_b_stb;
  logic          op_b_ack = 1'b0;
  logic [31:0]   op_z = '0;
  logic          op_z_stb = 1'b0;
  logic          op_z_ack;
  logic          busy;
  logic          stall_err;
  logic [CW-1:0] done_cnt;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] done_m = '0;
  logic stall_m = 1'b0;

  apx_float_op_driver #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_err(rsp_err),
    .op_a(op_a), .op_a_stb(op_a_stb), .op_a_ack(op_a_ack),
    .op_b(op_b), .op_b_stb(op_b_stb), .op_b_ack(op_b_ack),
    .op_z(op_z), .op_z_stb(op_z_stb), .op_z_ack(op_z_ack),
    .busy(busy), .stall_err(stall_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  // dz < 0: operator never produces Z. early: acks high before stb.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] zv, input int da, input int db,
                       input int dz, input int rw, input bit early,
                       input bit consec);
    int n;
    bit xf;
    bit to;
    logic [31:0] ez;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    if (early) begin
      op_a_ack = 1'b1;
      op_b_ack = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = $urandom;
    cmd_b = $urandom;
    total++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL accept busy/ready got=%b%b exp=10", busy, cmd_ready);
    end
    n = 0;
    xf = 1'b0;
    while (!xf && n < 20) begin
      total++;
      if (op_a_stb !== 1'b1 || op_a !== a || op_b_stb !== 1'b0
          || op_z_ack !== 1'b0) begin
        bad++;
        $display("FAIL a_phase stb_a/stb_b/zack=%b%b%b op_a=%h exp=100 %h",
                 op_a_stb, op_b_stb, op_z_ack, op_a, a);
      end
      op_z_stb = 1'($urandom % 2);
      if (!early) op_a_ack = (n >= da);
      @(posedge clk);
      xf = op_a_ack;
      @(negedge clk);
      if (!early) op_a_ack = 1'b0;
      n++;
    end
    if (consec) begin
      total++;
      if (n != 1) begin
        bad++;
        $display("FAIL a_latency got=%0d exp=1", n);
      end
    end
    n = 0;
    xf = 1'b0;
    while (!xf && n < 20) begin
      total++;
      if (op_b_stb !== 1'b1 || op_b !== b || op_a_stb !== 1'b0
          || op_z_ack !== 1'b0) begin
        bad++;
        $display("FAIL b_phase stb_b/stb_a/zack=%b%b%b op_b=%h exp=100 %h",
                 op_b_stb, op_a_stb, op_z_ack, op_b, b);
      end
      if (!early) op_b_ack = (n >= db);
      @(posedge clk);
      xf = op_b_ack;
      @(negedge clk);
      if (!early) op_b_ack = 1'b0;
      n++;
    end
    if (consec) begin
      total++;
      if (n != 1) begin
        bad++;
        $display("FAIL b_latency got=%0d exp=1", n);
      end
    end
    op_a_ack = 1'b0;
    op_b_ack = 1'b0;
    to = (dz < 0) || (dz >= TO);
    n = 0;
    xf = 1'b0;
    while (1) begin
      total++;
      if (op_z_ack !== 1'b1 || rsp_valid !== 1'b0 || op_b_stb !== 1'b0) begin
        bad++;
        $display("FAIL z_wait zack/rvalid/stb_b=%b%b%b exp=100",
                 op_z_ack, rsp_valid, op_b_stb);
      end
      op_z_stb = (dz >= 0) && (n >= dz);
      op_z = zv;
      @(posedge clk);
      xf = op_z_stb;
      @(negedge clk);
      op_z_stb = 1'b0;
      op_z = $urandom;
      n++;
      if (xf || n >= TO) break;
    end
    if (to) begin
      stall_m = 1'b1;
      ez = 32'h7FC0_0000;
    end else begin
      done_m = done_m + 1'b1;
      ez = zv;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_z !== ez || rsp_err !== to) begin
      bad++;
      $display("FAIL rsp valid/err=%b%b z=%h exp=1%b %h",
               rsp_valid, rsp_err, rsp_z, to, ez);
    end
    total++;
    if (stall_err !== stall_m || done_cnt !== done_m) begin
      bad++;
      $display("FAIL counters stall=%b done=%0d exp=%b %0d",
               stall_err, done_cnt, stall_m, done_m);
    end
    total++;
    if (op_a_stb !== 1'b0 || op_b_stb !== 1'b0 || op_z_ack !== 1'b0
        || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_outs a/b/zack/ready=%b%b%b%b exp=0000",
               op_a_stb, op_b_stb, op_z_ack, cmd_ready);
    end
    repeat (rw) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_z !== ez || cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL rsp_hold valid/ready=%b%b z=%h exp=10 %h",
                 rsp_valid, cmd_ready, rsp_z, ez);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rsp_done valid/ready/busy=%b%b%b exp=010",
               rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (rsp_valid !== 0 || rsp_err !== 0 || op_a_stb !== 0 || op_b_stb !== 0
        || op_z_ack !== 0 || busy !== 0 || stall_err !== 0 || done_cnt !== 0
        || op_a !== 0 || op_b !== 0 || rsp_z !== 0) begin
      bad++;
      $display("FAIL reset_state busy=%b done=%0d opa=%h z=%h exp=0 0 0 0",
               busy, done_cnt, op_a, rsp_z);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_basic;
    do_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_slow_ack;
    do_op(32'h3F80_0000, 32'hC020_0000, 32'hC020_0000, 5, 3, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rsp_backpressure;
    do_op($urandom, $urandom, $urandom, 1, 0, 1, 10, 1'b0, 1'b0);
    do_op($urandom, $urandom, $urandom, 0, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_timeout;
    do_op($urandom, $urandom, $urandom, 0, 0, -1, 2, 1'b0, 1'b0);
    do_op($urandom, $urandom, $urandom, 0, 0, TO - 1, 0, 1'b0, 1'b0);
    do_op($urandom, $urandom, $urandom, 2, 1, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset;
    cmd_valid = 1'b1;
    cmd_a = $urandom;
    cmd_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    op_a_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a_ack = 1'b0;
    total++;
    if (op_b_stb !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_in_b got=%b exp=1", op_b_stb);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (op_b_stb !== 0 || op_a_stb !== 0 || op_z_ack !== 0 || rsp_valid !== 0
        || busy !== 0 || stall_err !== 0 || done_cnt !== 0 || op_a !== 0
        || op_b !== 0) begin
      bad++;
      $display("FAIL mid_rst stb_b/busy/stall=%b%b%b done=%0d exp=000 0",
               op_b_stb, busy, stall_err, done_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_m = '0;
    stall_m = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_idle ready/busy=%b%b exp=10", cmd_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 17; i++) begin
      do_op($urandom, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 4), 0,
            1'($urandom % 2), 1'b0);
    end
    total++;
    if (done_cnt !== 4'd1) begin
      bad++;
      $display("FAIL wrap done_cnt got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      do_op($urandom, $urandom, $urandom, $urandom_range(0, 6),
            $urandom_range(0, 6), $urandom_range(0, 9),
            $urandom_range(0, 3), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slow_ack;
    test_rsp_backpressure;
    test_timeout;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
